// File: rtl/dcache_resp_ctrl_pkg.sv
// ============================================================================
// Module   : dcache_resp_ctrl_pkg
// Brief    : Shared types and lane helpers for the MEM-stage data responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dcache_resp_ctrl_pkg;

  typedef enum logic [1:0] {
    DC_IDLE = 2'd0,
    DC_REQ  = 2'd1,
    DC_WAIT = 2'd2,
    DC_RESP = 2'd3
  } dc_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_e;

  // Natural alignment: the offset must be a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
    case (mem_size_e'(size))
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (mem_size_e'(size))
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_resp_ctrl_lane_align.sv
// ============================================================================
// Module   : dmem_lane_align
// Brief    : Byte-lane steering between a right-aligned register and the 64-bit bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_lane_align
  import dcache_resp_ctrl_pkg::*;
(
  input  logic [2:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic        misalign,
  output logic [7:0]  wstrb,
  output logic [63:0] wdata_sh,
  output logic [63:0] rdata_sh
);

  logic [5:0] w_bit_off;

  assign w_bit_off = {addr_lo, 3'b000};
  assign misalign  = is_misaligned(addr_lo, size);
  assign wstrb     = size_mask(size) << addr_lo;
  assign wdata_sh  = wdata << w_bit_off;
  assign rdata_sh  = rdata >> w_bit_off;

endmodule

`default_nettype wire

// File: rtl/dcache_resp_ctrl.sv
// ============================================================================
// Module   : dcache_resp_ctrl
// Brief    : MEM-stage data responder; one outstanding bus transaction, stalls MEM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dcache_resp_ctrl
  import dcache_resp_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [63:0]       mem_addr_i,
  input  logic [63:0]       mem_wdata_i,
  input  logic [2:0]        funct3_i,
  input  logic              stall_i,
  output logic              dcache_data_valid_o,
  output logic [63:0]       dcache_data_o,
  output logic              misalign_o,
  output logic              err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [63:0]       bus_wdata_o,
  output logic [7:0]        bus_wstrb_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [63:0]       bus_rdata_i,
  input  logic              bus_err_i
);

  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYC - 1);

  dc_state_e   r_state;
  logic [7:0]  r_cnt;
  logic [2:0]  r_off;
  logic        r_we;
  logic [2:0]  w_off;
  logic        w_misalign;
  logic [7:0]  w_wstrb;
  logic [63:0] w_wdata_sh;
  logic [63:0] w_rdata_sh;
  logic        w_timeout;
  logic        w_unused_bits;

  assign w_off         = (r_state == DC_IDLE) ? mem_addr_i[2:0] : r_off;
  assign w_timeout     = (r_cnt >= c_TO_LAST);
  assign w_unused_bits = ^{mem_addr_i, funct3_i[2]};

  // Reset releases the pipeline immediately, even with a request still held in EX/MEM.
  assign dcache_data_valid_o = ~rst_n | (r_state == DC_RESP) |
                               ((r_state == DC_IDLE) & ~mem_req_i);

  dmem_lane_align u_lane_align (
    .addr_lo  (w_off),
    .size     (funct3_i[1:0]),
    .wdata    (mem_wdata_i),
    .rdata    (bus_rdata_i),
    .misalign (w_misalign),
    .wstrb    (w_wstrb),
    .wdata_sh (w_wdata_sh),
    .rdata_sh (w_rdata_sh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= DC_IDLE;
      r_cnt         <= '0;
      r_off         <= '0;
      r_we          <= 1'b0;
      dcache_data_o <= '0;
      misalign_o    <= 1'b0;
      err_o         <= 1'b0;
      bus_req_o     <= 1'b0;
      bus_we_o      <= 1'b0;
      bus_addr_o    <= '0;
      bus_wdata_o   <= '0;
      bus_wstrb_o   <= '0;
    end else begin
      case (r_state)
        DC_IDLE: begin
          r_cnt <= '0;
          if (mem_req_i && w_misalign) begin
            misalign_o    <= 1'b1;
            dcache_data_o <= '0;
            r_state       <= DC_RESP;
          end else if (mem_req_i) begin
            r_off       <= mem_addr_i[2:0];
            r_we        <= mem_we_i;
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_addr_o  <= {mem_addr_i[ADDR_W-1:3], 3'b000};
            bus_wdata_o <= mem_we_i ? w_wdata_sh : 64'd0;
            bus_wstrb_o <= mem_we_i ? w_wstrb : 8'd0;
            r_state     <= DC_REQ;
          end
        end
        DC_REQ: begin
          r_cnt <= r_cnt + 8'd1;
          if (bus_gnt_i || w_timeout) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_wstrb_o <= '0;
          end
          if (bus_gnt_i && bus_rvalid_i) begin
            dcache_data_o <= (r_we || bus_err_i) ? 64'd0 : w_rdata_sh;
            err_o         <= bus_err_i;
            r_state       <= DC_RESP;
          end else if (bus_gnt_i) begin
            r_state <= DC_WAIT;
          end else if (w_timeout) begin
            dcache_data_o <= '0;
            err_o         <= 1'b1;
            r_state       <= DC_RESP;
          end
        end
        DC_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          if (bus_rvalid_i) begin
            dcache_data_o <= (r_we || bus_err_i) ? 64'd0 : w_rdata_sh;
            err_o         <= bus_err_i;
            r_state       <= DC_RESP;
          end else if (w_timeout) begin
            dcache_data_o <= '0;
            err_o         <= 1'b1;
            r_state       <= DC_RESP;
          end
        end
        DC_RESP: begin
          r_cnt <= '0;
          if (!stall_i) begin
            dcache_data_o <= '0;
            misalign_o    <= 1'b0;
            err_o         <= 1'b0;
            r_state       <= DC_IDLE;
          end
        end
        default: r_state <= DC_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_resp_ctrl.sv
// ============================================================================
// Module   : tb_dcache_resp_ctrl
// Brief    : Scoreboard bench for dcache_resp_ctrl with a scripted bus responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dcache_resp_ctrl;

  localparam int TO = 255;

  logic        clk;
  logic        rst_n;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [63:0] mem_addr_i;
  logic [63:0] mem_wdata_i;
  logic [2:0]  funct3_i;
  logic        stall_i;
  logic        dcache_data_valid_o;
  logic [63:0] dcache_data_o;
  logic        misalign_o;
  logic        err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [63:0] bus_wdata_o;
  logic [7:0]  bus_wstrb_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [63:0] bus_rdata_i;
  logic        bus_err_i;

  typedef struct {
    logic [63:0] data;
    logic        mis;
    logic        err;
    int          lat;
    int          t0;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  strb;
    int          g;
    int          r;
    logic [63:0] rdata;
    logic        berr;
    logic        to;
    logic        nogrant;
  } plan_t;

  resp_t resp_q[$];
  plan_t plan_q[$];
  int    n_checks = 0;
  int    n_err    = 0;
  int    nc       = 0;

  dcache_resp_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .mem_req_i           (mem_req_i),
    .mem_we_i            (mem_we_i),
    .mem_addr_i          (mem_addr_i),
    .mem_wdata_i         (mem_wdata_i),
    .funct3_i            (funct3_i),
    .stall_i             (stall_i),
    .dcache_data_valid_o (dcache_data_valid_o),
    .dcache_data_o       (dcache_data_o),
    .misalign_o          (misalign_o),
    .err_o               (err_o),
    .bus_req_o           (bus_req_o),
    .bus_we_o            (bus_we_o),
    .bus_addr_o          (bus_addr_o),
    .bus_wdata_o         (bus_wdata_o),
    .bus_wstrb_o         (bus_wstrb_o),
    .bus_gnt_i           (bus_gnt_i),
    .bus_rvalid_i        (bus_rvalid_i),
    .bus_rdata_i         (bus_rdata_i),
    .bus_err_i           (bus_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: compares every presented response cycle, pops on handshake.
  initial begin : monitor
    resp_t e;
    bit    first;
    first = 1'b1;
    forever begin
      @(negedge clk);
      nc++;
      if (!mem_req_i) begin
        chk("idle_valid_flags", 64'({dcache_data_valid_o, misalign_o, err_o}), 64'(3'b100));
      end else if (dcache_data_valid_o) begin
        if (resp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_resp: valid with data %h, expected no response", dcache_data_o);
        end else begin
          e = resp_q[0];
          chk("resp_data", dcache_data_o, e.data);
          chk("resp_misalign", 64'(misalign_o), 64'(e.mis));
          chk("resp_err", 64'(err_o), 64'(e.err));
          if (first) begin
            chk("resp_latency", 64'(nc - e.t0), 64'(e.lat));
            first = 1'b0;
          end
          if (!stall_i) begin
            void'(resp_q.pop_front());
            first = 1'b1;
          end
        end
      end
    end
  end

  // Bus responder: follows the plan queued by the stimulus for each aligned access.
  initial begin : responder
    plan_t p;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = '0;
    bus_err_i    = 1'b0;
    forever begin
      step();
      if (bus_req_o) begin
        if (plan_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL bus_req: unexpected request addr %h, expected no request", bus_addr_o);
        end else begin
          p = plan_q.pop_front();
          chk("bus_addr", 64'(bus_addr_o), 64'(p.addr));
          chk("bus_we", 64'(bus_we_o), 64'(p.we));
          chk("bus_wdata", bus_wdata_o, p.wdata);
          chk("bus_wstrb", 64'(bus_wstrb_o), 64'(p.strb));
          if (p.nogrant) begin
            for (int k = 0; k < TO + 10 && bus_req_o; k++) step();
            chk("bus_req_drop", 64'(bus_req_o), 64'd0);
          end else begin
            for (int k = 0; k < p.g; k++) begin
              step();
              chk("bus_hold", 64'({bus_req_o, bus_addr_o}), 64'({1'b1, p.addr}));
            end
            bus_gnt_i = 1'b1;
            if (!p.to && p.r == 0) begin
              bus_rvalid_i = 1'b1;
              bus_rdata_i  = p.rdata;
              bus_err_i    = p.berr;
            end
            step();
            bus_gnt_i    = 1'b0;
            bus_rvalid_i = 1'b0;
            bus_err_i    = 1'b0;
            if (!p.to && p.r > 0) begin
              for (int k = 1; k < p.r; k++) step();
              bus_rvalid_i = 1'b1;
              bus_rdata_i  = p.rdata;
              bus_err_i    = p.berr;
              step();
              bus_rvalid_i = 1'b0;
              bus_err_i    = 1'b0;
            end
          end
        end
      end
    end
  end

  // Reference model: expectations from plain byte arithmetic on the request.
  task automatic run_txn(input logic we, input logic [1:0] sz, input logic [63:0] addr,
                         input logic [63:0] wd, input int g, input int r, input logic [63:0] rd,
                         input logic berr, input logic to, input logic nogrant, input int nstall_in);
    resp_t e;
    plan_t p;
    int    bytes;
    int    off;
    int    n;
    int    nstall;
    bit    done;
    bytes  = 1 << sz;
    off    = int'(addr[2:0]);
    nstall = nstall_in;
    e.mis  = (addr % 64'(bytes)) != 64'd0;
    e.err  = e.mis ? 1'b0 : (to ? 1'b1 : berr);
    e.data = (e.mis || we || e.err) ? 64'd0 : (rd >> (8 * off));
    e.lat  = e.mis ? 1 : (to ? 1 + TO : 2 + g + r);
    p.addr    = addr[31:0] & 32'hFFFF_FFF8;
    p.we      = we;
    p.wdata   = we ? (wd << (8 * off)) : 64'd0;
    p.strb    = 8'd0;
    if (we) begin
      for (int b = 0; b < bytes; b++)
        if (off + b < 8) p.strb[off + b] = 1'b1;
    end
    p.g       = g;
    p.r       = r;
    p.rdata   = rd;
    p.berr    = berr;
    p.to      = to;
    p.nogrant = nogrant;

    step();
    e.t0 = nc + 1;
    resp_q.push_back(e);
    if (!e.mis) plan_q.push_back(p);
    mem_req_i   = 1'b1;
    mem_we_i    = we;
    mem_addr_i  = addr;
    mem_wdata_i = wd;
    funct3_i    = {1'($urandom_range(0, 1)), sz};
    stall_i     = (nstall > 0);
    done = 1'b0;
    n    = 0;
    while (!done && n < TO + 20) begin
      @(negedge clk);
      n++;
      if (dcache_data_valid_o) begin
        if (!stall_i) done = 1'b1;
        else nstall--;
      end
      step();
      stall_i = (!done && nstall > 0);
    end
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL handshake: no response after %0d cycles, expected one by %0d", n, e.lat);
    end
    mem_req_i = 1'b0;
    mem_we_i  = 1'b0;
    stall_i   = 1'b0;
    repeat ($urandom_range(0, 2)) step();
  endtask

  task automatic reset_mid(input logic nogrant);
    plan_t p;
    p = '{addr: 32'h3000, we: 1'b0, wdata: 64'd0, strb: 8'd0, g: 0, r: 0,
          rdata: 64'd0, berr: 1'b0, to: 1'b1, nogrant: nogrant};
    plan_q.push_back(p);
    step();
    mem_req_i  = 1'b1;
    mem_we_i   = 1'b0;
    mem_addr_i = 64'h3000;
    funct3_i   = 3'b011;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_bus_req", 64'(bus_req_o), 64'd0);
    chk("rst_mid_valid", 64'(dcache_data_valid_o), 64'd1);
    mem_req_i = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  initial begin : stimulus
    logic        we;
    logic [1:0]  sz;
    logic [63:0] a;
    int          off;
    logic        to;
    rst_n       = 1'b0;
    mem_req_i   = 1'b0;
    mem_we_i    = 1'b0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    funct3_i    = '0;
    stall_i     = 1'b0;

    step();
    chk("reset_outputs", 64'({bus_req_o, bus_we_o, bus_wstrb_o, misalign_o, err_o}), 64'd0);
    chk("reset_bus_addr", 64'(bus_addr_o), 64'd0);
    chk("reset_bus_wdata", bus_wdata_o, 64'd0);
    chk("reset_data", dcache_data_o, 64'd0);
    chk("reset_valid", 64'(dcache_data_valid_o), 64'd1);
    step();
    rst_n = 1'b1;

    repeat (10) begin
      @(negedge clk);
      chk("noreq_valid", 64'(dcache_data_valid_o), 64'd1);
      chk("noreq_bus_req", 64'(bus_req_o), 64'd0);
    end

    run_txn(1'b0, 2'd3, 64'h1000, 64'd0, 0, 1, 64'h1122334455667788, 1'b0, 1'b0, 1'b0, 0);
    run_txn(1'b0, 2'd0, 64'h1005, 64'd0, 0, 1, 64'h1122334455667788, 1'b0, 1'b0, 1'b0, 0);
    run_txn(1'b1, 2'd1, 64'h2006, 64'hBEEF, 1, 2, 64'hDEAD_0000_DEAD_0000, 1'b0, 1'b0, 1'b0, 1);
    run_txn(1'b0, 2'd2, 64'h1002, 64'd0, 0, 0, 64'd0, 1'b0, 1'b0, 1'b0, 0);
    run_txn(1'b0, 2'd2, 64'h1004, 64'd0, 0, 0, 64'hCAFE_F00D_1234_5678, 1'b0, 1'b0, 1'b0, 0);
    run_txn(1'b0, 2'd3, 64'h4000, 64'd0, 0, 0, 64'd0, 1'b0, 1'b1, 1'b0, 3);
    reset_mid(1'b0);
    reset_mid(1'b1);

    for (int i = 0; i < 60; i++) begin
      we  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      a   = {$urandom(), $urandom()};
      off = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0) off = off & ~((1 << sz) - 1);
      a[2:0] = 3'(off);
      to  = ($urandom_range(0, 19) == 0);
      run_txn(we, sz, a, {$urandom(), $urandom()}, $urandom_range(0, 3), $urandom_range(0, 3),
              {$urandom(), $urandom()}, ($urandom_range(0, 7) == 0), to,
              to && ($urandom_range(0, 1) == 1), $urandom_range(0, 2));
    end

    repeat (4) step();
    chk("resp_queue_drained", 64'(resp_q.size()), 64'd0);
    chk("plan_queue_drained", 64'(plan_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
